// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module : sw_debounce_pkg
// Shared constants for the switch debouncer: timing defaults and FSM encoding.
// Rev    : 1.0
// ============================================================================
package sw_debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int SIM_DEBOUNCE_CYCLES     = 8;
  localparam int SYNC_STAGES             = 2;

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module : debounce_ch
// One switch channel: synchroniser, stable-time counter, edge pulses, toggle.
// Rev    : 1.0
// ============================================================================
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_toggle
);

  localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [0:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_toggle;

  logic                   w_sync_out;
  logic                   w_mismatch;
  logic [CNT_W-1:0]       w_cnt_cur;
  logic                   w_done;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync_out ^ r_level;
  // A fresh mismatch out of STABLE always counts from zero.
  assign w_cnt_cur  = (r_state == ST_PENDING) ? r_cnt : '0;
  assign w_done     = w_mismatch && (w_cnt_cur == c_TERMINAL);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_sync   <= '0;
      r_state  <= ST_STABLE;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_mismatch) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
      end else if (w_done) begin
        r_state  <= ST_STABLE;
        r_cnt    <= '0;
        r_level  <= ~r_level;
        r_rise   <= ~r_level;
        r_fall   <= r_level;
        r_toggle <= r_toggle ^ ~r_level;
      end else begin
        r_state <= ST_PENDING;
        r_cnt   <= w_cnt_cur + CNT_W'(1);
      end
    end
  end

  assign o_level  = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_toggle = r_toggle;

endmodule
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module : sw_debounce
// NUM_CH independent debounced switch channels with edge pulses and toggles.
// Rev    : 1.0
// ============================================================================
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] i_sw,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_toggle
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_sw     (i_sw[g]),
      .o_level  (o_level[g]),
      .o_rise   (o_rise[g]),
      .o_fall   (o_fall[g]),
      .o_toggle (o_toggle[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side companion to the LED toggle/blink path: reads raw board switches/buttons and delivers clean, clock-aligned levels and single-cycle edge events to the rest of the design.
- Per channel: 2-flop synchroniser, stable-time debounce counter, rise/fall pulses, and a press-to-toggle latch usable directly as an LED/toggle enable.

Parameters:
- NUM_CH, 4, number of independent switch channels.
- DEBOUNCE_CYCLES, 1000000, consecutive clk edges a new value must hold before acceptance (10 ms at 100 MHz); legal range 1 to 2^CNT_W-1.
- CNT_W, 32, debounce counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-high reset (asserted = 1), sampled on clk rising edge.
- i_sw  input  NUM_CH  raw asynchronous switch/button inputs.
- o_level  output  NUM_CH  debounced level per channel.
- o_rise  output  NUM_CH  one-cycle pulse when o_level goes 0->1.
- o_fall  output  NUM_CH  one-cycle pulse when o_level goes 1->0.
- o_toggle  output  NUM_CH  inverts on every o_rise (press-to-toggle enable).

Behaviour:
- Reset (reset_n=1 at an edge): sync flops, counter, o_level, o_rise, o_fall, o_toggle all -> 0. Reset mid-count discards the count. Reset dominates all other events on the same edge.
- Synchroniser: sync1 <= i_sw; sync2 <= sync1. Only sync2 feeds the debounce logic.
- Per-channel FSM, two states:
  - STABLE: sync2 == o_level; counter held at 0.
  - PENDING: sync2 != o_level; counter increments each edge.
- Transitions:
  - STABLE -> PENDING on the first edge where sync2 != o_level.
  - PENDING -> STABLE with no output change if sync2 returns to o_level before the count completes (glitch rejected, counter cleared). A later mismatch restarts from 0.
  - o_level flips on the DEBOUNCE_CYCLES-th consecutive edge at which sync2 != o_level. Counter clears on that edge.
- Latency: a clean step on i_sw appears on o_level DEBOUNCE_CYCLES+2 edges later. With DEBOUNCE_CYCLES=1 this is pure synchroniser delay plus 1.
- o_rise/o_fall are registered and asserted on the same edge o_level flips; high for exactly one cycle. They are never both high on one channel, and cannot repeat within DEBOUNCE_CYCLES cycles.
- o_toggle <= ~o_toggle on the edge where o_rise is asserted. o_fall has no effect on it.
- Counter compares against DEBOUNCE_CYCLES-1 and never wraps; it saturates logically because reaching the terminal value always flips the level and clears.
- Channels are fully independent. Simultaneous events on several channels are handled in parallel with no arbitration.
- Inputs held constant out of reset produce no pulses if 0. If 1, o_level rises after DEBOUNCE_CYCLES+2 edges with one o_rise, and o_toggle -> 1.

Decomposition:
- Shared package (sw_debounce_pkg):
  - DEFAULT_DEBOUNCE_CYCLES = 1000000
  - SIM_DEBOUNCE_CYCLES = 8
  - SYNC_STAGES = 2
  - state encoding constants ST_STABLE = 1'b0, ST_PENDING = 1'b1
- Sub-module debounce_ch: one channel (synchroniser, counter, FSM, pulse and toggle registers).
- Top instantiates NUM_CH copies via generate and concatenates outputs.

Test Plan (DEBOUNCE_CYCLES=8, NUM_CH=4):
- Clean press: i_sw[0] 0->1 held -> o_level[0]=1 exactly 10 edges later, o_rise[0] high 1 cycle, o_toggle[0]=1. Other channels unchanged.
- Bounce rejection: i_sw[1] pulses high 5 cycles, low 3, high 5, then low -> o_level[1], o_rise[1], o_toggle[1] stay 0 throughout.
- Release: after the clean press, i_sw[0] 1->0 held -> o_level[0]=0 10 edges later, o_fall[0] 1 cycle, o_toggle[0] stays 1. A second press -> o_toggle[0]=0.
- Simultaneous: i_sw=4'b1111 on one edge -> all o_level bits rise on the same edge 10 later, o_rise=4'b1111 for one cycle.
- Reset mid-count: i_sw[2]=1 for 6 cycles, reset_n=1 one cycle, i_sw[2] held 1 -> no pulse before reset. o_level[2] rises 10 edges after reset deasserts, not earlier.
- DEBOUNCE_CYCLES=1 build: i_sw[3] 0->1 -> o_level[3]=1 after 3 edges with one o_rise. A 1-cycle glitch propagates as rise then fall.
